// File: rtl/scm_bist_pkg.sv
// Shared definitions for the latch register-file March BIST controller:
// the controller state encoding and the width of the mismatch counter.
package scm_bist_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      W0    = 3'd1,
      R0W1  = 3'd2,
      R1W0  = 3'd3,
      R0    = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam int FAIL_CNT_WIDTH = 8;

endpackage

// File: rtl/scm_bist_addr_gen.sv
// Up/down address counter for the March elements. A load sets the start
// address of an element; tc flags the last address in the current direction.
module scm_bist_addr_gen
   import scm_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_val,
   input  logic                  en,
   input  logic                  down,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  tc
);

   // Address register: load has priority over counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_val;
      end else if (en) begin
         addr <= down ? addr - 1'b1 : addr + 1'b1;
      end
   end

   assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/scm_bist_ctrl.sv
// March C- style BIST controller for a latch register file:
// W0, R0W1 (up), R1W0 (down), R0 (up), one DRAIN cycle, then DONE.
// Optional macro SCM_BIST_FAIL_LOG_EN adds FailAddr/FailCount logging;
// without it both outputs are constant zero and no log registers exist.
module scm_bist_ctrl
   import scm_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      Start,
   input  logic                      Abort,
   input  logic [DATA_WIDTH-1:0]     Pattern,
   output logic                      BIST,
   output logic                      CSN_T,
   output logic                      WEN_T,
   output logic [ADDR_WIDTH-1:0]     A_T,
   output logic [DATA_WIDTH-1:0]     D_T,
   output logic [NUM_BYTE-1:0]       BE_T,
   input  logic [DATA_WIDTH-1:0]     Q_T,
   output logic                      Busy,
   output logic                      Done,
   output logic                      Fail,
   output logic [ADDR_WIDTH-1:0]     FailAddr,
   output logic [FAIL_CNT_WIDTH-1:0] FailCount
);

   state_t                  state, state_nxt;
   logic                    ph, ph_nxt;
   logic                    ld, cnt_en, cnt_dn, tc;
   logic [ADDR_WIDTH-1:0]   ld_val;
   logic                    busy_st, start_ok, abort_take;
   logic                    op_nxt, wr_nxt, busy_nxt;
   logic [DATA_WIDTH-1:0]   pat_q, pat_src, d_nxt;
   logic                    rd_now;
   logic [DATA_WIDTH-1:0]   exp_now;
   logic                    vld_p1;
   logic [DATA_WIDTH-1:0]   exp_p1;
   logic                    mism_p1;

   assign busy_st    = (state != IDLE) && (state != DONE);
   assign start_ok   = Start && !Abort && !busy_st;
   assign abort_take = Abort && busy_st;
   assign pat_src    = start_ok ? Pattern : pat_q;
   assign cnt_dn     = (state == R1W0);

   scm_bist_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .en       (cnt_en),
      .down     (cnt_dn),
      .addr     (A_T),
      .tc       (tc)
   );

   // State and read/write sub-phase registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ph    <= 1'b0;
      end else begin
         state <= state_nxt;
         ph    <= ph_nxt;
      end
   end

   // Next-state logic: element sequencing and address counter control.
   always_comb begin
      state_nxt = state;
      ph_nxt    = ph;
      ld        = 1'b0;
      ld_val    = '0;
      cnt_en    = 1'b0;
      if (abort_take) begin
         state_nxt = IDLE;
         ph_nxt    = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  state_nxt = W0;
                  ph_nxt    = 1'b0;
                  ld        = 1'b1;
               end
            end
            W0: begin
               if (tc) begin
                  state_nxt = R0W1;
                  ld        = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            R0W1: begin
               if (!ph) begin
                  ph_nxt = 1'b1;
               end else begin
                  ph_nxt = 1'b0;
                  if (tc) begin
                     state_nxt = R1W0;
                     ld        = 1'b1;
                     ld_val    = '1;
                  end else begin
                     cnt_en = 1'b1;
                  end
               end
            end
            R1W0: begin
               if (!ph) begin
                  ph_nxt = 1'b1;
               end else begin
                  ph_nxt = 1'b0;
                  if (tc) begin
                     state_nxt = R0;
                     ld        = 1'b1;
                  end else begin
                     cnt_en = 1'b1;
                  end
               end
            end
            R0: begin
               if (tc) begin
                  state_nxt = DRAIN;
               end else begin
                  cnt_en = 1'b1;
               end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Decode of the upcoming cycle's memory operation, so outputs can be registered.
   always_comb begin
      op_nxt   = (state_nxt == W0) || (state_nxt == R0W1) ||
                 (state_nxt == R1W0) || (state_nxt == R0);
      wr_nxt   = (state_nxt == W0) ||
                 (((state_nxt == R0W1) || (state_nxt == R1W0)) && ph_nxt);
      busy_nxt = op_nxt || (state_nxt == DRAIN);
      case (state_nxt)
         W0, R1W0, R0: d_nxt = pat_src;
         R0W1:         d_nxt = ~pat_src;
         default:      d_nxt = D_T;
      endcase
   end

   // Registered memory-side and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         BIST  <= 1'b0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         CSN_T <= 1'b1;
         WEN_T <= 1'b1;
         BE_T  <= '0;
         D_T   <= '0;
      end else begin
         BIST  <= busy_nxt;
         Busy  <= busy_nxt;
         Done  <= (state_nxt == DONE);
         CSN_T <= !op_nxt;
         WEN_T <= !wr_nxt;
         BE_T  <= op_nxt ? '1 : '0;
         D_T   <= d_nxt;
      end
   end

   // Background word captured on an accepted Start.
   always_ff @(posedge clk) begin
      if (start_ok) begin
         pat_q <= Pattern;
      end
   end

   assign rd_now  = !CSN_T && WEN_T;
   assign exp_now = (state == R1W0) ? ~pat_q : pat_q;
   assign mism_p1 = vld_p1 && (Q_T != exp_p1);

   // ---- stage p1: expected word travels with the read, compared against Q_T ----
   // Compare-valid flag; an abort drops the compare still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_now && !abort_take;
      end
   end

   // Expected word for the read issued this cycle.
   always_ff @(posedge clk) begin
      exp_p1 <= exp_now;
   end

   // Sticky mismatch flag, cleared by an accepted Start.
   always_ff @(posedge clk) begin
      if (rst) begin
         Fail <= 1'b0;
      end else if (start_ok) begin
         Fail <= 1'b0;
      end else if (mism_p1) begin
         Fail <= 1'b1;
      end
   end

`ifdef SCM_BIST_FAIL_LOG_EN
   logic [ADDR_WIDTH-1:0] addr_p1;

   // Address of the read issued this cycle, aligned with exp_p1.
   always_ff @(posedge clk) begin
      addr_p1 <= A_T;
   end

   // First-failure address and saturating mismatch count.
   always_ff @(posedge clk) begin
      if (rst) begin
         FailAddr  <= '0;
         FailCount <= '0;
      end else if (start_ok) begin
         FailAddr  <= '0;
         FailCount <= '0;
      end else if (mism_p1) begin
         if (!Fail) begin
            FailAddr <= addr_p1;
         end
         if (FailCount != '1) begin
            FailCount <= FailCount + 1'b1;
         end
      end
   end
`else
   assign FailAddr  = '0;
   assign FailCount = '0;
`endif

endmodule

// File: tb/tb_scm_bist_ctrl.sv
// Directed bench for scm_bist_ctrl with an ideal one-cycle-latency memory
// model and an optional stuck-at-0 fault on bit 3 of address 7.
// Log expectations follow SCM_BIST_FAIL_LOG_EN.
module tb_scm_bist_ctrl;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NB = DW / 8;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          Start = 1'b0;
   logic          Abort = 1'b0;
   logic [DW-1:0] Pattern = '0;
   logic          BIST, CSN_T, WEN_T, Busy, Done, Fail;
   logic [AW-1:0] A_T, FailAddr;
   logic [DW-1:0] D_T, Q_T;
   logic [NB-1:0] BE_T;
   logic [7:0]    FailCount;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [0:N-1];
   logic          stuck_en = 1'b0;

`ifdef SCM_BIST_FAIL_LOG_EN
   localparam logic [AW-1:0] STUCK_ADDR_EXP = 5'd7;
   localparam logic [7:0]    STUCK_CNT_EXP  = 8'd1;
`else
   localparam logic [AW-1:0] STUCK_ADDR_EXP = 5'd0;
   localparam logic [7:0]    STUCK_CNT_EXP  = 8'd0;
`endif

   scm_bist_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_BYTE   (NB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .Start     (Start),
      .Abort     (Abort),
      .Pattern   (Pattern),
      .BIST      (BIST),
      .CSN_T     (CSN_T),
      .WEN_T     (WEN_T),
      .A_T       (A_T),
      .D_T       (D_T),
      .BE_T      (BE_T),
      .Q_T       (Q_T),
      .Busy      (Busy),
      .Done      (Done),
      .Fail      (Fail),
      .FailAddr  (FailAddr),
      .FailCount (FailCount)
   );

   always #5 clk = ~clk;

   // Ideal memory: write stored at the edge, read data presented the cycle after.
   always @(posedge clk) begin
      if (!CSN_T) begin
         if (!WEN_T) begin
            if (stuck_en && A_T == 5'd7) mem[A_T] <= D_T & ~32'h0000_0008;
            else                         mem[A_T] <= D_T;
         end else begin
            Q_T <= mem[A_T];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [DW-1:0] pat);
      Pattern = pat;
      Start   = 1'b1;
      tick();
      Start   = 1'b0;
      Pattern = 32'h1234_5678;
   endtask

   // Full run with cycle-exact op/address/data checks; optional Start noise while busy.
   task automatic run_march(input logic [DW-1:0] pat, input bit noise, input string tag);
      bit            op, wr;
      int            j;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      int            bad;
      start_run(pat);
      for (int k = 0; k <= 6 * N; k++) begin
         ed = pat;
         if (k < N) begin
            op = 1; wr = 1; ea = AW'(k);
         end else if (k < 3 * N) begin
            j = k - N; op = 1; wr = (j % 2) == 1; ea = AW'(j / 2); ed = ~pat;
         end else if (k < 5 * N) begin
            j = k - 3 * N; op = 1; wr = (j % 2) == 1; ea = AW'(N - 1 - j / 2);
         end else if (k < 6 * N) begin
            op = 1; wr = 0; ea = AW'(k - 5 * N);
         end else begin
            op = 0; wr = 0; ea = '0;
         end
         bad = 0;
         if ({Busy, BIST, CSN_T} !== {1'b1, 1'b1, !op}) bad = 1;
         if (op && (WEN_T !== !wr || A_T !== ea || BE_T !== 4'hF)) bad = 1;
         if (op && wr && D_T !== ed) bad = 1;
         if (k == 0 && {Done, Fail} !== 2'b00) bad = 1;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s cycle %0d: got busy=%b bist=%b csn=%b wen=%b a=%0d d=%h be=%h done=%b fail=%b, want busy=1 bist=1 csn=%b wen=%b a=%0d d=%h",
                     tag, k, Busy, BIST, CSN_T, WEN_T, A_T, D_T, BE_T, Done, Fail, !op, !wr, ea, ed);
         end
         Start = noise && (k % 37 == 5);
         tick();
      end
      Start = 1'b0;
      checks++;
      if ({Busy, BIST, CSN_T, WEN_T, Done} !== 5'b00111) begin
         errors++;
         $display("FAIL %s_end: got busy=%b bist=%b csn=%b wen=%b done=%b, want 0 0 1 1 1",
                  tag, Busy, BIST, CSN_T, WEN_T, Done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({BIST, CSN_T, WEN_T, A_T, D_T, BE_T, Busy, Done, Fail, FailAddr, FailCount} !==
          {1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset: got bist=%b csn=%b wen=%b a=%0d d=%h be=%h busy=%b done=%b fail=%b fa=%0d fc=%0d, want 0 1 1 0 0 0 0 0 0 0 0",
                  BIST, CSN_T, WEN_T, A_T, D_T, BE_T, Busy, Done, Fail, FailAddr, FailCount);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({Busy, Done, CSN_T} !== 3'b001) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b csn=%b, want 0 0 1", Busy, Done, CSN_T);
      end
   endtask

   task automatic test_clean_run();
      stuck_en = 1'b0;
      run_march(32'hA5A5_A5A5, 1'b0, "clean_seq");
      checks++;
      if ({Fail, FailAddr, FailCount} !== {1'b0, 5'd0, 8'd0}) begin
         errors++;
         $display("FAIL clean_result: got fail=%b fa=%0d fc=%0d, want 0 0 0", Fail, FailAddr, FailCount);
      end
   endtask

   task automatic test_stuck_fault();
      stuck_en = 1'b1;
      run_march(32'h0, 1'b0, "stuck_seq");
      checks++;
      if ({Fail, FailAddr, FailCount} !== {1'b1, STUCK_ADDR_EXP, STUCK_CNT_EXP}) begin
         errors++;
         $display("FAIL stuck_result: got fail=%b fa=%0d fc=%0d, want 1 %0d %0d",
                  Fail, FailAddr, FailCount, STUCK_ADDR_EXP, STUCK_CNT_EXP);
      end
   endtask

   // Restart from DONE after the failing run (clears Done/Fail), with Start noise.
   task automatic test_start_in_done();
      stuck_en = 1'b0;
      run_march(32'h5A5A_0FF0, 1'b1, "restart_seq");
      checks++;
      if (Fail !== 1'b0) begin
         errors++;
         $display("FAIL restart_fail: got %b, want 0", Fail);
      end
   endtask

   task automatic test_abort();
      stuck_en = 1'b0;
      start_run(32'hA5A5_A5A5);
      for (int k = 0; k < 40; k++) tick();
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      checks++;
      if ({BIST, CSN_T, WEN_T, Busy, Done} !== 5'b01100) begin
         errors++;
         $display("FAIL abort40: got bist=%b csn=%b wen=%b busy=%b done=%b, want 0 1 1 0 0",
                  BIST, CSN_T, WEN_T, Busy, Done);
      end
      // Abort after the stuck-at fault is logged: log must survive.
      stuck_en = 1'b1;
      start_run(32'h0);
      for (int k = 0; k < 150; k++) tick();
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      checks++;
      if ({Busy, Done, Fail, FailAddr, FailCount} !== {1'b0, 1'b0, 1'b1, STUCK_ADDR_EXP, STUCK_CNT_EXP}) begin
         errors++;
         $display("FAIL abort_retain: got busy=%b done=%b fail=%b fa=%0d fc=%0d, want 0 0 1 %0d %0d",
                  Busy, Done, Fail, FailAddr, FailCount, STUCK_ADDR_EXP, STUCK_CNT_EXP);
      end
      // Abort and Start together in IDLE: no start.
      Abort = 1'b1;
      Start = 1'b1;
      tick();
      Abort = 1'b0;
      Start = 1'b0;
      tick();
      checks++;
      if ({Busy, BIST, CSN_T, Fail} !== 4'b0011) begin
         errors++;
         $display("FAIL abort_start_idle: got busy=%b bist=%b csn=%b fail=%b, want 0 0 1 1",
                  Busy, BIST, CSN_T, Fail);
      end
      stuck_en = 1'b0;
      run_march(32'hFFFF_0000, 1'b0, "after_abort_seq");
   endtask

   task automatic test_reset_midrun();
      stuck_en = 1'b0;
      start_run(32'h3C3C_C3C3);
      for (int k = 0; k < 100; k++) tick();
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_busy: got %b, want 1", Busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({BIST, CSN_T, WEN_T, A_T, D_T, BE_T, Busy, Done, Fail, FailAddr, FailCount} !==
          {1'b0, 1'b1, 1'b1, 5'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0}) begin
         errors++;
         $display("FAIL midrun_reset: got bist=%b csn=%b wen=%b a=%0d d=%h be=%h busy=%b done=%b fail=%b fa=%0d fc=%0d, want 0 1 1 0 0 0 0 0 0 0 0",
                  BIST, CSN_T, WEN_T, A_T, D_T, BE_T, Busy, Done, Fail, FailAddr, FailCount);
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_stuck_fault();
      test_start_in_done();
      test_abort();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scm_bist_ctrl.md
SCM_BIST_CTRL -- requirements
Module: scm_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving the address width of the target latch register file (N = 2**ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the word width.
REQ-003 SHALL have parameter NUM_BYTE, default DATA_WIDTH/8, giving the byte-enable width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 Start  in  1  single-cycle run request.
REQ-008 Abort  in  1  stop the current run.
REQ-009 Pattern  in  DATA_WIDTH  background word; latched at accepted Start.
REQ-010 BIST  out  1  test-mode select to the register-file wrapper.
REQ-011 CSN_T  out  1  chip select, active-low.
REQ-012 WEN_T  out  1  write enable, active-low.
REQ-013 A_T  out  ADDR_WIDTH  test address.
REQ-014 D_T  out  DATA_WIDTH  test write data.
REQ-015 BE_T  out  NUM_BYTE  test byte enables.
REQ-016 Q_T  in  DATA_WIDTH  read data; valid one cycle after a read is issued.
REQ-017 Busy  out  1  run in progress.
REQ-018 Done  out  1  run completed; held until the next accepted Start.
REQ-019 Fail  out  1  sticky mismatch flag.
REQ-020 FailAddr  out  ADDR_WIDTH  address of the first mismatch.
REQ-021 FailCount  out  8  mismatch count, saturating at 255.

Function
REQ-022 All outputs SHALL be registered.
REQ-023 States SHALL be IDLE, W0, R0W1, R1W0, R0, DRAIN, DONE.
REQ-024 Start SHALL be accepted in IDLE or DONE only; it is ignored while Busy.
REQ-025 An accepted Start SHALL latch Pattern, clear Done/Fail/FailAddr/FailCount, and enter W0 on the next cycle.
REQ-026 W0: ascending 0..N-1, one write of Pattern per cycle (N cycles).
REQ-027 R0W1: ascending; per address, one read cycle expecting Pattern, then one write cycle of ~Pattern (2N cycles).
REQ-028 R1W0: descending N-1..0; per address, one read cycle expecting ~Pattern, then one write cycle of Pattern (2N cycles).
REQ-029 R0: ascending, one read per cycle expecting Pattern (N cycles); then DRAIN for 1 cycle, then DONE.
REQ-030 Total run length SHALL be 6N+1 cycles of Busy=1; for N=32 this is 193 cycles.
REQ-031 Read cycle encoding: CSN_T=0, WEN_T=1. Write cycle encoding: CSN_T=0, WEN_T=0. BE_T SHALL be all ones during any operation.
REQ-032 CSN_T=1 and WEN_T=1 SHALL hold in IDLE and DONE; BIST=1 exactly while Busy=1.
REQ-033 The expected word and the address SHALL be pipelined one stage; Q_T SHALL be compared in the cycle after each read, including the DRAIN cycle.
REQ-034 On mismatch, Fail SHALL be set. FailCount SHALL increment, saturating at 255. FailAddr SHALL be captured only if this is the first mismatch of the run.
REQ-035 Address wrap at N-1 (ascending) or 0 (descending) SHALL terminate the element and advance the state; there is no extra idle cycle between elements.
REQ-036 Abort while Busy SHALL return to IDLE on the next cycle with BIST=0, CSN_T=1, Busy=0, Done=0. Fail, FailAddr and FailCount SHALL be retained, and the pending compare is dropped.
REQ-037 Abort and Start in the same cycle in IDLE/DONE: Abort SHALL win (no start).

Reset
REQ-038 rst SHALL force IDLE, BIST=0, CSN_T=1, WEN_T=1, A_T=0, D_T=0, BE_T=0, Busy=0, Done=0, Fail=0, FailAddr=0, FailCount=0, including mid-run.

Configuration
REQ-039 Macro SCM_BIST_FAIL_LOG_EN defined: FailAddr and FailCount SHALL be implemented per REQ-034.
REQ-040 SCM_BIST_FAIL_LOG_EN undefined: FailAddr and FailCount SHALL be tied to 0, with no log registers; Fail SHALL be unaffected.

Structure
REQ-041 Package scm_bist_pkg SHALL hold the state enum typedef and the constant FAIL_CNT_WIDTH=8.
REQ-042 One sub-module, scm_bist_addr_gen, SHALL provide the up/down address counter with load and terminal-count flag.

Verification
REQ-043 Ideal 1-cycle-latency memory model, Pattern=0xA5A5A5A5, Start pulse -> 193 Busy cycles, exact op/address/data sequence per REQ-026..029, Done=1, Fail=0.
REQ-044 Model with bit 3 of address 7 stuck-at-0, Pattern=0 -> Fail=1, FailAddr=7, FailCount=1 (R1W0 read).
REQ-045 Abort on Busy cycle 40 -> next cycle BIST=0, CSN_T=1, Busy=0, Done=0; a new Start then completes normally.
REQ-046 Start pulses during Busy ignored (run still 193 cycles); Start in DONE after a failing run clears Fail and Done.
REQ-047 rst asserted on Busy cycle 100 -> all outputs at REQ-038 values next cycle.
REQ-048 Build without SCM_BIST_FAIL_LOG_EN, REQ-044 stimulus -> Fail=1, FailAddr=0, FailCount=0.
